// File: rtl/exec_alu_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exec_alu_unit_pkg
// Purpose  : Shared definitions for the execute stage. Holds the default
//            widths, the op-code constants and the FSM state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package exec_alu_unit_pkg;

  localparam int WIDTH_DEF      = 32;
  localparam int REG_ADDR_W_DEF = 5;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SLT = 4'd5;
  localparam logic [3:0] OP_SLL = 4'd6;
  localparam logic [3:0] OP_SRL = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MUL  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/exec_alu_unit_seq_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier
// Purpose  : Iterative shift-add multiplier producing the low WIDTH bits of
//            an unsigned product, one multiplier bit per step.
// Ports    : clk, rst (async active-low)
//            load         - capture operands, clear accumulator and counter
//            step         - perform one shift-add iteration
//            multiplicand - operand A
//            multiplier   - operand B
//            product      - accumulated low WIDTH bits
//            countDone    - MUL_STEPS iterations have been performed
// Revision : 1.0 - initial release
// ============================================================================
module seq_multiplier
  import exec_alu_unit_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int MUL_STEPS = WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] product,
  output logic             countDone
);

  localparam int             CNT_W  = $clog2(MUL_STEPS + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MUL_STEPS);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (load) begin
      r_mcand  <= multiplicand;
      r_mplier <= multiplier;
      r_acc    <= '0;
      r_count  <= '0;
    end else if (step && !countDone) begin
      // Bits shifted out of the multiplicand only affect the discarded
      // upper half of the product, so truncation here is intentional.
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_count  <= r_count + C_ONE;
    end
  end

  assign product   = r_acc;
  assign countDone = (r_count == C_LAST);

endmodule
`default_nettype wire

// File: rtl/exec_alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : exec_alu_unit
// Purpose  : Execute stage behind the register file. Single-cycle ALU ops
//            plus an iterative multiply, with a registered write-back port.
// Ports    : clk, rst (async active-low)
//            start, op, rdAddr, operandA, operandB - request (IDLE only)
//            busy      - op in flight
//            done      - one-cycle completion pulse
//            wbEn      - register-file write enable (never for r0/illegal)
//            wbReg     - write-back address (held until next completion)
//            wbData    - result (held until next completion)
//            zero      - result == 0, valid with done
//            illegalOp - pulses with done for op codes 9..15
// Revision : 1.0 - initial release
// ============================================================================
module exec_alu_unit
  import exec_alu_unit_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int MUL_STEPS  = WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [3:0]            op,
  input  logic [REG_ADDR_W-1:0] rdAddr,
  input  logic [WIDTH-1:0]      operandA,
  input  logic [WIDTH-1:0]      operandB,
  output logic                  busy,
  output logic                  done,
  output logic                  wbEn,
  output logic [REG_ADDR_W-1:0] wbReg,
  output logic [WIDTH-1:0]      wbData,
  output logic                  zero,
  output logic                  illegalOp
);

  localparam int SHAMT_W = $clog2(WIDTH);

  state_t                r_state;
  logic [3:0]            r_op;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [WIDTH-1:0]      r_a;
  logic [WIDTH-1:0]      r_b;

  logic [WIDTH-1:0]      w_result;
  logic                  w_legal;
  logic [SHAMT_W-1:0]    w_shamt;
  logic                  w_accept;
  logic                  w_finish;
  logic                  w_mulLoad;
  logic                  w_mulStep;
  logic                  w_mulDone;
  logic [WIDTH-1:0]      w_product;

  assign w_shamt   = r_b[SHAMT_W-1:0];
  assign w_accept  = (r_state == ST_IDLE) && start;
  // The multiplier takes its operands straight from the ports on the
  // accepting edge, in step with the operand capture below.
  assign w_mulLoad = w_accept && (op == OP_MUL);
  assign w_mulStep = (r_state == ST_MUL) && !w_mulDone;
  assign w_finish  = (r_state == ST_EXEC) || ((r_state == ST_MUL) && w_mulDone);

  seq_multiplier #(
    .WIDTH     (WIDTH),
    .MUL_STEPS (MUL_STEPS)
  ) u_mul (
    .clk          (clk),
    .rst          (rst),
    .load         (w_mulLoad),
    .step         (w_mulStep),
    .multiplicand (operandA),
    .multiplier   (operandB),
    .product      (w_product),
    .countDone    (w_mulDone)
  );

  // Illegal op codes fall through with a zero result.
  always_comb begin
    w_result = '0;
    w_legal  = 1'b1;
    case (r_op)
      OP_ADD:  w_result = r_a + r_b;
      OP_SUB:  w_result = r_a - r_b;
      OP_AND:  w_result = r_a & r_b;
      OP_OR:   w_result = r_a | r_b;
      OP_XOR:  w_result = r_a ^ r_b;
      OP_SLT:  w_result = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      OP_SLL:  w_result = r_a << w_shamt;
      OP_SRL:  w_result = r_a >> w_shamt;
      OP_MUL:  w_result = w_product;
      default: w_legal  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_op      <= '0;
      r_rd      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      wbEn      <= 1'b0;
      wbReg     <= '0;
      wbData    <= '0;
      zero      <= 1'b0;
      illegalOp <= 1'b0;
    end else begin
      done      <= 1'b0;
      wbEn      <= 1'b0;
      illegalOp <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op    <= op;
            r_rd    <= rdAddr;
            r_a     <= operandA;
            r_b     <= operandB;
            busy    <= 1'b1;
            r_state <= (op == OP_MUL) ? ST_MUL : ST_EXEC;
          end
        end
        ST_EXEC, ST_MUL: begin
          if (w_finish) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            wbReg     <= r_rd;
            wbData    <= w_result;
            zero      <= (w_result == '0);
            illegalOp <= !w_legal;
            wbEn      <= w_legal && (r_rd != '0);
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exec_alu_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_exec_alu_unit
// Purpose  : Scoreboard bench for exec_alu_unit. The driver predicts each
//            accepted request's result and completion edge; a monitor checks
//            every cycle's outputs against the queue of predictions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exec_alu_unit;

  localparam int MUL_STEPS = 32;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        zero;
    logic        ill;
    logic        en;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  op;
  logic [4:0]  rdAddr;
  logic [31:0] operandA;
  logic [31:0] operandB;
  logic        busy;
  logic        done;
  logic        wbEn;
  logic [4:0]  wbReg;
  logic [31:0] wbData;
  logic        zero;
  logic        illegalOp;

  int   cyc    = 0;
  int   nTests = 0;
  int   nFail  = 0;
  int   accE   = 0;
  int   doneE  = 0;
  exp_t q[$];
  exp_t mExp;
  logic [4:0]  holdReg  = '0;
  logic [31:0] holdData = '0;

  exec_alu_unit dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .rdAddr    (rdAddr),
    .operandA  (operandA),
    .operandB  (operandB),
    .busy      (busy),
    .done      (done),
    .wbEn      (wbEn),
    .wbReg     (wbReg),
    .wbData    (wbData),
    .zero      (zero),
    .illegalOp (illegalOp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference behaviour straight from the op-code table.
  function automatic logic [31:0] refAlu(input logic [3:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] p;
    case (o)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return a << b[4:0];
      4'd7: return a >> b[4:0];
      4'd8: begin
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
      end
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nTests++;
    if (act !== expv) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Drive one cycle of inputs; if the model says the unit is free at the
  // coming edge and start is high, predict the completion.
  task automatic drive(input logic s, input logic [3:0] o, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    int   e;
    exp_t x;
    @(negedge clk);
    start = s; op = o; rdAddr = rd; operandA = a; operandB = b;
    e = cyc + 1;
    if (s && rst && e > doneE) begin
      accE   = e;
      doneE  = e + ((o == 4'd8) ? 1 + MUL_STEPS : 1);
      x.ill  = (o > 4'd8);
      x.rd   = rd;
      x.data = refAlu(o, a, b);
      x.zero = (x.data == 32'd0);
      x.en   = !x.ill && (rd != 5'd0);
      x.due  = doneE;
      q.push_back(x);
    end
  endtask

  task automatic idle();
    drive(1'b0, 4'($urandom_range(0, 15)), 5'($urandom), $urandom, $urandom);
  endtask

  task automatic issue(input logic [3:0] o, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b);
    drive(1'b1, o, rd, a, b);
    while (cyc + 1 <= doneE) idle();
  endtask

  task automatic chkResetOutputs();
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst wbEn", 32'(wbEn), 32'd0);
    chk("rst wbReg", 32'(wbReg), 32'd0);
    chk("rst wbData", wbData, 32'd0);
    chk("rst zero", 32'(zero), 32'd0);
    chk("rst illegalOp", 32'(illegalOp), 32'd0);
  endtask

  // Monitor: sample well after the active edge.
  always @(posedge clk) begin
    #3;
    if (!rst) begin
      q.delete();
      holdReg  = '0;
      holdData = '0;
    end else begin
      if (q.size() > 0 && cyc == q[0].due) begin
        mExp = q.pop_front();
        chk("done", 32'(done), 32'd1);
        chk("wbEn", 32'(wbEn), 32'(mExp.en));
        chk("wbReg", 32'(wbReg), 32'(mExp.rd));
        chk("wbData", wbData, mExp.data);
        chk("zero", 32'(zero), 32'(mExp.zero));
        chk("illegalOp", 32'(illegalOp), 32'(mExp.ill));
        holdReg  = mExp.rd;
        holdData = mExp.data;
      end else begin
        chk("done idle", 32'(done), 32'd0);
        chk("wbEn idle", 32'(wbEn), 32'd0);
        chk("illegalOp idle", 32'(illegalOp), 32'd0);
        chk("wbReg hold", 32'(wbReg), 32'(holdReg));
        chk("wbData hold", wbData, holdData);
      end
      chk("busy", 32'(busy), 32'((cyc >= accE) && (cyc < doneE)));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  o;
    rst = 1'b0; start = 1'b0; op = '0; rdAddr = '0; operandA = '0; operandB = '0;
    repeat (3) @(negedge clk);
    #1 chkResetOutputs();
    @(negedge clk);
    rst = 1'b1;

    // Multiply aborted by reset part-way through: nothing may be written.
    drive(1'b1, 4'd8, 5'd6, 32'h0001_0003, 32'd5);
    while (cyc < 10) idle();
    @(negedge clk);
    rst = 1'b0; accE = 0; doneE = 0;
    #1 chkResetOutputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) idle();

    // Directed cases.
    issue(4'd0, 5'd4, 32'd7, 32'd13);
    issue(4'd1, 5'd1, 32'd0, 32'd1);
    issue(4'd5, 5'd2, 32'hFFFF_FFFF, 32'd1);
    issue(4'd7, 5'd3, 32'h8000_0000, 32'd31);
    issue(4'd6, 5'd5, 32'h0000_0001, 32'd31);
    issue(4'd8, 5'd6, 32'h0001_0003, 32'h0000_0005);
    issue(4'd8, 5'd7, 32'hFFFF_FFFF, 32'd2);
    issue(4'd0, 5'd0, 32'd5, 32'd6);
    issue(4'd12, 5'd9, 32'd3, 32'd4);
    issue(4'd1, 5'd8, 32'd9, 32'd9);

    // start held through a multiply, an ADD offered mid-flight, then an
    // immediate reissue on the first cycle the unit is free again.
    for (int i = 0; i < 34; i++) begin
      if (i == 10) drive(1'b1, 4'd0, 5'd11, 32'd1, 32'd2);
      else         drive(1'b1, 4'd8, 5'd10, 32'd1234, 32'd5678);
    end
    issue(4'd0, 5'd12, 32'd100, 32'd200);
    issue(4'd2, 5'd13, 32'hF0F0_F0F0, 32'h0FF0_0FF0);

    // Random traffic, including requests that arrive while busy.
    for (int i = 0; i < 200; i++) begin
      o = ($urandom_range(0, 5) == 0) ? 4'd8 : 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       a = 32'hFFFF_FFFF;
        1:       a = 32'($urandom_range(0, 3));
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      drive(1'($urandom_range(0, 2) != 0), o, 5'($urandom), a, b);
    end

    for (int k = 0; k < 100 && q.size() > 0; k++) idle();
    idle();
    chk("scoreboard drained", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
`default_nettype wire
